// File: rtl/dram_responder.sv
// ---------------------------------------------------------------------------
// dram_responder
//
// Memory-side responder for the data-cache miss-repair handshake. Accepts one
// request at a time from the cache controller, waits a fixed access latency,
// then returns one data word with a single-cycle mem_ready strobe.
//
// Handshake: mem_req is a level held by the controller until it sees
// mem_ready. mem_req is sampled only in IDLE. Once a request is taken, the
// access always completes with exactly one mem_ready pulse, even if mem_req
// drops meanwhile. The FSM then parks in RELEASE until mem_req is low, so a
// request held high across its response is never served twice.
//
// Optional feature macro: DRAM_WRITE_EN
//   defined   : mem_we/mem_wdata honoured. The write commits at the edge
//               entering RESP, and the response echoes the written word.
//   undefined : every request is a read. Storage is read-only and word i
//               holds i[data-1:0].
//
// Ports:
//   clk              in   single clock, rising edge
//   rst              in   asynchronous active-low reset
//   mem_req          in   request level from cache controller
//   mem_addr[31:0]   in   byte address of the request
//   mem_we           in   1 = write, 0 = read (sampled with mem_req)
//   mem_wdata        in   write data (sampled with mem_req)
//   mem_ready        out  one-cycle response strobe
//   dram_data_output out  response data, valid while mem_ready = 1
//   busy             out  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module dram_responder #(
    parameter int data      = 11,
    parameter int mem_words = 2048,
    parameter int addr_lsb  = 3,
    parameter int latency   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_req,
    input  logic [31:0]     mem_addr,
    input  logic            mem_we,
    input  logic [data-1:0] mem_wdata,
    output logic            mem_ready,
    output logic [data-1:0] dram_data_output,
    output logic            busy
);

    localparam int IW = $clog2(mem_words);
    localparam int CW = $clog2(latency + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx_q;
    logic            we_q;
    logic [data-1:0] wdata_q;

    // Two-flop deassertion: reset assertion reaches the FSM immediately,
    // but the FSM may only leave IDLE after two clean edges out of reset.
    logic [1:0]      rst_sync;
    logic            run_ok;

    logic [IW-1:0]   addr_idx;
    logic            req_we;
    logic            accept;
    logic [IW-1:0]   cur_idx;
    logic            cur_we;
    logic [data-1:0] cur_wdata;
    logic [data-1:0] rd_word;
    logic [data-1:0] resp_word;
    logic            unused_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run_ok = rst_sync[1];

    // Upper address bits are ignored, so addresses wrap modulo mem_words.
    assign addr_idx = mem_addr[addr_lsb + IW - 1 : addr_lsb];

`ifdef DRAM_WRITE_EN
    assign req_we    = mem_we;
    assign unused_in = ^mem_addr;
`else
    assign req_we    = 1'b0;
    assign unused_in = ^{mem_addr, mem_we};
`endif

    assign accept = (state == IDLE) && mem_req && run_ok;

    // With latency 1 the response is produced straight from IDLE, so the
    // access uses the live request fields rather than the latched copies.
    assign cur_idx   = (state == IDLE) ? addr_idx  : idx_q;
    assign cur_we    = (state == IDLE) ? req_we    : we_q;
    assign cur_wdata = (state == IDLE) ? mem_wdata : wdata_q;

`ifdef DRAM_WRITE_EN
    typedef logic [data-1:0] store_t [mem_words];

    function automatic store_t store_init();
        store_t s;
        for (int i = 0; i < mem_words; i++) begin
            s[i] = data'(i);
        end
        return s;
    endfunction

    // Storage is deliberately outside the reset domain: a reset must leave
    // previously committed writes intact.
    store_t store = store_init();

    always_ff @(posedge clk) begin
        if ((state_nx == RESP) && cur_we) begin
            store[cur_idx] <= cur_wdata;
        end
    end

    assign rd_word = store[cur_idx];
`else
    // Read-only contents are the word index itself, so no array is needed.
    assign rd_word = data'(cur_idx);
`endif

    assign resp_word = cur_we ? cur_wdata : rd_word;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (latency == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = RELEASE;
            end
            RELEASE: begin
                if (!mem_req) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            cnt              <= '0;
            idx_q            <= '0;
            we_q             <= 1'b0;
            wdata_q          <= '0;
            mem_ready        <= 1'b0;
            dram_data_output <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                idx_q   <= addr_idx;
                we_q    <= req_we;
                wdata_q <= mem_wdata;
                cnt     <= CW'(latency - 1);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            // Strobe and data are registered on the edge entering RESP.
            mem_ready <= (state_nx == RESP);
            if (state_nx == RESP) begin
                dram_data_output <= resp_word;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dram_responder.sv
// ---------------------------------------------------------------------------
// tb_dram_responder
//
// Bench for dram_responder. A driver issues requests (directed cases, then
// random ones) and pushes the expected response word and response cycle into
// queues. A monitor pops and compares on every mem_ready. The reference
// model is a plain word array indexed by (addr >> addr_lsb) % mem_words.
// A second instance with latency = 1 covers the shortest-latency path.
// ---------------------------------------------------------------------------
module tb_dram_responder;

    localparam int DATA  = 11;
    localparam int WORDS = 2048;
    localparam int LSB   = 3;
    localparam int LAT   = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT (default latency) ----------------
    logic            mem_req   = 1'b0;
    logic [31:0]     mem_addr  = '0;
    logic            mem_we    = 1'b0;
    logic [DATA-1:0] mem_wdata = '0;
    logic            mem_ready;
    logic [DATA-1:0] dout;
    logic            busy;

    dram_responder #(.data(DATA), .mem_words(WORDS), .addr_lsb(LSB), .latency(LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_we           (mem_we),
        .mem_wdata        (mem_wdata),
        .mem_ready        (mem_ready),
        .dram_data_output (dout),
        .busy             (busy)
    );

    // ---------------- DUT (latency 1) ----------------
    logic            req1   = 1'b0;
    logic [31:0]     addr1  = '0;
    logic            we1    = 1'b0;
    logic [DATA-1:0] wdata1 = '0;
    logic            ready1;
    logic [DATA-1:0] dout1;
    logic            busy1;

    dram_responder #(.data(DATA), .mem_words(WORDS), .addr_lsb(LSB), .latency(1)) dut_l1 (
        .clk              (clk),
        .rst              (rst),
        .mem_req          (req1),
        .mem_addr         (addr1),
        .mem_we           (we1),
        .mem_wdata        (wdata1),
        .mem_ready        (ready1),
        .dram_data_output (dout1),
        .busy             (busy1)
    );

    // ---------------- scoreboard state ----------------
    int              checks = 0;
    int              errors = 0;
    logic [DATA-1:0] exp_q[$];
    int              exp_cyc_q[$];
    logic [DATA-1:0] model_mem [WORDS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [DATA-1:0] e;
        int              c;
        if (rst && mem_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready at cycle %0d: got data 0x%0h, expected no response", cyc, dout);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("resp_data", 32'(dout), 32'(e));
                check("resp_cycle", c == cyc ? 32'd1 : 32'd0, 32'd1);
                if (c != cyc) $display("  response cycle %0d, expected %0d", cyc, c);
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle. hold = extra cycles mem_req stays
    // high after mem_ready; early = drop mem_req during the wait.
    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [DATA-1:0] wd,
                          input int hold, input bit early);
        int              idx;
        logic [DATA-1:0] e;
        bit              seen;
        idx = int'((addr >> LSB) % WORDS);
`ifdef DRAM_WRITE_EN
        if (we) begin
            model_mem[idx] = wd;
            e = wd;
        end else begin
            e = model_mem[idx];
        end
`else
        e = model_mem[idx];
`endif
        mem_addr  = addr;
        mem_we    = we;
        mem_wdata = wd;
        mem_req   = 1'b1;
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 1 + LAT);
        seen = 1'b0;
        for (int t = 1; t <= LAT + 8 && !seen; t++) begin
            @(negedge clk);
            if (t == 1) begin
                check("busy_after_accept", 32'(busy), 32'd1);
                if (early) mem_req = 1'b0;
            end
            if (mem_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout at cycle %0d: got no mem_ready, expected one within %0d cycles", cyc, LAT);
            exp_q.delete();
            exp_cyc_q.delete();
        end
        repeat (hold) @(negedge clk);
        mem_req = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
        check("data_hold", 32'(dout), 32'(e));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < WORDS; i++) model_mem[i] = DATA'(i);

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(dout), 32'd0);
        check("rst_ready_l1", 32'(ready1), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Directed: plain read, wrap, write/read, long hold, early drop.
        do_txn(32'h0000_0018, 1'b0, '0, 0, 1'b0);
        do_txn(32'h0000_4018, 1'b0, '0, 0, 1'b0);
        do_txn(32'h0000_0020, 1'b1, 11'h5A5, 0, 1'b0);
        do_txn(32'h0000_0020, 1'b0, '0, 0, 1'b0);
        do_txn(32'h0000_0040, 1'b0, '0, 12, 1'b0);
        do_txn(32'h0000_0048, 1'b0, '0, 0, 1'b1);

        // Reset mid-WAIT: a pending write to word 3 must be dropped.
        mem_addr  = 32'h0000_0018;
        mem_we    = 1'b1;
        mem_wdata = 11'h2AA;
        mem_req   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready", 32'(mem_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", 32'(dout), 32'd0);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        do_txn(32'h0000_0018, 1'b0, '0, 0, 1'b0);

        // Latency 1: response in the cycle after the acceptance edge.
        addr1 = 32'h0000_0038;
        req1  = 1'b1;
        @(negedge clk);
        check("l1_ready", 32'(ready1), 32'd1);
        check("l1_data", 32'(dout1), 32'(((addr1 >> LSB) % WORDS)));
        check("l1_busy", 32'(busy1), 32'd1);
        req1 = 1'b0;
        @(negedge clk);
        check("l1_ready_drop", 32'(ready1), 32'd0);
        @(negedge clk);
        check("l1_idle", 32'(busy1), 32'd0);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            do_txn($urandom, 1'($urandom_range(0, 1)), DATA'($urandom_range(0, 2047)),
                   int'($urandom_range(0, 4)), $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
